adc_sample_source: RTL



---
 rtl/adc_sample_source_if.sv | 28 ++
 rtl/adc_sample_source.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/adc_sample_source_if.sv
// Serial ADC pins plus the parallel sample bus presented to the filter.
// Latency: n/a (wires only).
// Backpressure: none; the sample bus is a strobe-qualified push with no ready.
//   master: adc_cs_n, adc_sclk, dout, data_refresh out; adc_miso in
//   slave : the mirror image (ADC model plus filter input)
interface adc_sample_source_if;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_miso;
    logic [15:0] dout;
    logic        data_refresh;

    modport master (
        output adc_cs_n,
        output adc_sclk,
        output dout,
        output data_refresh,
        input  adc_miso
    );

    modport slave (
        input  adc_cs_n,
        input  adc_sclk,
        input  dout,
        input  data_refresh,
        output adc_miso
    );
endinterface

// File: rtl/adc_sample_source.sv
// Periodic SPI mode-0 reader of a 16-bit ADC, emitting signed samples with a strobe.
// Latency: cs_n falls 1 cycle after a tick; data_refresh CS_SETUP+32*CLK_DIV+CS_HOLD cycles later.
// Backpressure: none; a tick arriving while a frame is in flight is dropped and flagged in overrun.
//   ports: clk, rst_n, enable, sample_period[15:0], clear_overrun, busy, overrun,
//          bus (master): adc_cs_n, adc_sclk, adc_miso, dout[15:0], data_refresh
module adc_sample_source #(
    parameter int CLK_DIV       = 2,
    parameter int CS_SETUP      = 2,
    parameter int CS_HOLD       = 2,
    parameter int OFFSET_BINARY = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [15:0]                sample_period,
    input  logic                       clear_overrun,
    adc_sample_source_if.master        bus,
    output logic                       busy,
    output logic                       overrun
);

    // One counter serves the setup, bit-phase and hold intervals.
    localparam int M1      = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int MAX_CYC = (M1 > 2 * CLK_DIV) ? M1 : 2 * CLK_DIV;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(2 * CLK_DIV - 1);
    localparam logic [15:0]   FMT_MASK   = (OFFSET_BINARY != 0) ? 16'h8000 : 16'h0000;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

    state_t        state;
    logic [CW-1:0] cyc;
    logic [3:0]    bit_cnt;
    logic [15:0]   shreg;
    logic          cs_n_r;
    logic          sclk_r;
    logic [15:0]   dout_r;
    logic          refresh_r;

    // Pacing timer. tmr_run marks that tmr holds a live count; on the first
    // enabled cycle (and after reset) the count is taken straight from
    // sample_period, so the first tick lands sample_period cycles after enable.
    logic [15:0] tmr;
    logic        tmr_run;
    logic [15:0] tmr_eff;
    logic        tick;

    always_comb begin
        tmr_eff = tmr_run ? tmr : sample_period;
        tick    = enable && (tmr_eff <= 16'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr     <= '0;
            tmr_run <= 1'b0;
        end else begin
            tmr_run <= enable;
            if (!enable || tick) begin
                tmr <= sample_period;
            end else begin
                tmr <= tmr_eff - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cyc       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            cs_n_r    <= 1'b1;
            sclk_r    <= 1'b0;
            dout_r    <= '0;
            refresh_r <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            refresh_r <= 1'b0;

            // A new drop outranks a simultaneous clear.
            if (tick && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (tick) begin
                        state  <= S_SETUP;
                        cs_n_r <= 1'b0;
                        busy   <= 1'b1;
                        cyc    <= '0;
                    end
                end
                S_SETUP: begin
                    if (cyc == SETUP_LAST) begin
                        state   <= S_SHIFT;
                        cyc     <= '0;
                        bit_cnt <= '0;
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                S_SHIFT: begin
                    // Each bit: CLK_DIV cycles low, then CLK_DIV high. MISO is
                    // captured on the edge that raises sclk; the ADC changed it
                    // on the previous falling edge, so it is settled here.
                    if (cyc == HALF_LAST) begin
                        sclk_r <= 1'b1;
                        shreg  <= {shreg[14:0], bus.adc_miso};
                        cyc    <= cyc + CW'(1);
                    end else if (cyc == BIT_LAST) begin
                        sclk_r <= 1'b0;
                        cyc    <= '0;
                        if (bit_cnt == 4'd15) begin
                            state <= S_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (cyc == HOLD_LAST) begin
                        state     <= S_DONE;
                        cs_n_r    <= 1'b1;
                        dout_r    <= shreg ^ FMT_MASK;
                        refresh_r <= 1'b1;
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.adc_cs_n     = cs_n_r;
    assign bus.adc_sclk     = sclk_r;
    assign bus.dout         = dout_r;
    assign bus.data_refresh = refresh_r;

endmodule
